ps2_key_decoder: RTL

//  Upstream stage of the game-logic block. Receives PS/2 keyboard frames, decodes make codes into 3-bit

---
 rtl/game_pkg.sv | 74 +++++++
 rtl/ps2_receiver.sv | 70 +++++++
 rtl/ps2_key_decoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the keyboard front end of the game-logic block:
// operation codes, scancode constants and the make-code lookup.
package game_pkg;

    typedef enum logic [2:0] {
        OP_W     = 3'b000,
        OP_A     = 3'b001,
        OP_S     = 3'b010,
        OP_D     = 3'b011,
        OP_SPACE = 3'b100,
        OP_Z     = 3'b101,
        OP_NONE  = 3'b110
    } op_t;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_BRK,
        SC_EXT,
        SC_EXT_BRK
    } sc_state_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_READY,
        H_WAIT_LOW
    } hs_state_t;

    typedef struct packed {
        logic hit;
        op_t  op;
    } key_map_t;

    localparam logic [7:0] MAKE_W     = 8'h1D;
    localparam logic [7:0] MAKE_A     = 8'h1C;
    localparam logic [7:0] MAKE_S     = 8'h1B;
    localparam logic [7:0] MAKE_D     = 8'h23;
    localparam logic [7:0] MAKE_SPACE = 8'h29;
    localparam logic [7:0] MAKE_Z     = 8'h1A;
    localparam logic [7:0] ARROW_UP   = 8'h75;
    localparam logic [7:0] ARROW_LT   = 8'h6B;
    localparam logic [7:0] ARROW_DN   = 8'h72;
    localparam logic [7:0] ARROW_RT   = 8'h74;
    localparam logic [7:0] BREAK      = 8'hF0;
    localparam logic [7:0] EXT        = 8'hE0;

    function automatic key_map_t map_plain(input logic [7:0] code);
        key_map_t m;
        m = '{hit: 1'b1, op: OP_NONE};
        case (code)
            MAKE_W:     m.op = OP_W;
            MAKE_A:     m.op = OP_A;
            MAKE_S:     m.op = OP_S;
            MAKE_D:     m.op = OP_D;
            MAKE_SPACE: m.op = OP_SPACE;
            MAKE_Z:     m.op = OP_Z;
            default:    m.hit = 1'b0;
        endcase
        return m;
    endfunction

    function automatic key_map_t map_ext(input logic [7:0] code);
        key_map_t m;
        m = '{hit: 1'b1, op: OP_NONE};
        case (code)
            ARROW_UP: m.op = OP_W;
            ARROW_LT: m.op = OP_A;
            ARROW_DN: m.op = OP_S;
            ARROW_RT: m.op = OP_D;
            default:  m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_receiver.sv
// PS/2 byte receiver: pin synchronisers, falling-edge detect,
// 11-bit frame capture with start/stop/odd-parity check and timeout.
module ps2_receiver #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int LOG2_TIMEOUT   = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data
);
    localparam logic [LOG2_TIMEOUT-1:0] T_MAX = LOG2_TIMEOUT'(TIMEOUT_CYCLES);
    localparam logic [LOG2_TIMEOUT-1:0] T_ONE = LOG2_TIMEOUT'(1);

    logic [1:0]              clk_sync;
    logic [1:0]              dat_sync;
    logic                    clk_prev;
    logic [3:0]              bit_cnt;
    logic [9:0]              shift;
    logic [LOG2_TIMEOUT-1:0] tcnt;
    logic                    fall;
    logic [10:0]             full;
    logic                    frame_ok;

    assign fall     = clk_prev & ~clk_sync[1];
    assign full     = {dat_sync[1], shift};
    assign frame_ok = ~full[0] & full[10] & (^full[9:1]);

    // Synchronisers reset to the idle-high line level so no edge is seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_prev   <= 1'b1;
            bit_cnt    <= 4'd0;
            shift      <= 10'd0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clock};
            dat_sync   <= {dat_sync[0], ps2_data};
            clk_prev   <= clk_sync[1];
            byte_valid <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        byte_valid <= 1'b1;
                        byte_data  <= full[8:1];
                    end
                end else if (!(bit_cnt == 4'd0 && dat_sync[1])) begin
                    shift   <= {dat_sync[1], shift[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (tcnt == T_MAX) begin
                    tcnt    <= '0;
                    bit_cnt <= 4'd0;
                end else begin
                    tcnt <= tcnt + T_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 make codes into game operations and hands them to the
// game logic one at a time over a ready/read_fin 4-phase handshake.
module ps2_key_decoder
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int LOG2_TIMEOUT   = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       keyboard_read_fin,
    output logic       keyboard_ready,
    output logic [2:0] keyboard_data,
    output logic [7:0] scancode_o_test
);
    logic       byte_valid;
    logic [7:0] byte_data;
    sc_state_t  sc_state;
    sc_state_t  sc_next;
    hs_state_t  hs_state;
    key_map_t   plain_hit;
    key_map_t   ext_hit;
    logic       emit;
    op_t        emit_op;

    ps2_receiver #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .LOG2_TIMEOUT  (LOG2_TIMEOUT)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data)
    );

    assign plain_hit = map_plain(byte_data);
    assign ext_hit   = map_ext(byte_data);

    always_comb begin
        sc_next = sc_state;
        emit    = 1'b0;
        emit_op = OP_NONE;
        if (byte_valid) begin
            case (sc_state)
                SC_IDLE: begin
                    sc_next = SC_IDLE;
                    if (byte_data == BREAK) begin
                        sc_next = SC_BRK;
                    end else if (byte_data == EXT) begin
                        sc_next = SC_EXT;
                    end else if (plain_hit.hit) begin
                        emit    = 1'b1;
                        emit_op = plain_hit.op;
                    end
                end
                SC_EXT: begin
                    sc_next = SC_IDLE;
                    if (byte_data == BREAK) begin
                        sc_next = SC_EXT_BRK;
                    end else if (ext_hit.hit) begin
                        emit    = 1'b1;
                        emit_op = ext_hit.op;
                    end
                end
                default: sc_next = SC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sc_state        <= SC_IDLE;
            scancode_o_test <= 8'h00;
        end else begin
            sc_state <= sc_next;
            if (byte_valid) scancode_o_test <= byte_data;
        end
    end

    // Emits arriving while an operation is outstanding are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_state       <= H_IDLE;
            keyboard_ready <= 1'b0;
            keyboard_data  <= OP_NONE;
        end else begin
            case (hs_state)
                H_IDLE: begin
                    if (emit) begin
                        keyboard_data  <= emit_op;
                        keyboard_ready <= 1'b1;
                        hs_state       <= H_READY;
                    end
                end
                H_READY: begin
                    if (keyboard_read_fin) begin
                        keyboard_ready <= 1'b0;
                        hs_state       <= H_WAIT_LOW;
                    end
                end
                H_WAIT_LOW: begin
                    if (!keyboard_read_fin) begin
                        if (emit) begin
                            keyboard_data  <= emit_op;
                            keyboard_ready <= 1'b1;
                            hs_state       <= H_READY;
                        end else begin
                            hs_state <= H_IDLE;
                        end
                    end
                end
                default: hs_state <= H_IDLE;
            endcase
        end
    end

endmodule
